// File: rtl/nanoz80_uart_pkg.sv
// Shared types and constants for the nanoz80 serial console peripheral.
package nanoz80_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_RX_AVAIL    = 0;
    localparam int STAT_TX_NOT_FULL = 1;
    localparam int STAT_RX_OVERRUN  = 2;
    localparam int STAT_FRAMING_ERR = 3;
    localparam int STAT_TX_BUSY     = 4;

endpackage

// File: rtl/nanoz80_uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push.
module nanoz80_uart_fifo
    import nanoz80_uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: empty pointers make the contents unobservable.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/nanoz80_uart.sv
// nanoz80 serial console: 8N1 transmitter and receiver, each behind a FIFO,
// exposed to the Z80 as a DATA/STATUS register pair.
module nanoz80_uart
    import nanoz80_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cs_i,
    input  logic       wr_n_i,
    input  logic       rd_n_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       irq_n_o
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic       wr_acc, rd_acc, wr_acc_q, rd_acc_q, rd_addr_q;
    logic       wr_stb, tx_push, stat_wr, rx_pop;
    logic       tx_full, tx_empty, tx_pop;
    logic [7:0] tx_head;
    logic       rx_full, rx_empty, rx_push, rx_frame_err, rx_stop_sample;
    logic [7:0] rx_head;
    logic       rx_irq_en, rx_overrun, framing_err;
    logic [7:0] status;
    logic       unused_addr;

    uart_state_t tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    uart_state_t rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_meta, rx_sync, rx_wait_high;

    assign unused_addr = ^addr_i[7:1];

    assign wr_acc = cs_i & ~wr_n_i;
    assign rd_acc = cs_i & ~rd_n_i;

    // Strobes span several clocks; remember the previous level so writes act on
    // the first cycle and reads pop only once the strobe is released.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_acc_q  <= 1'b0;
            rd_acc_q  <= 1'b0;
            rd_addr_q <= 1'b0;
        end else begin
            wr_acc_q <= wr_acc;
            rd_acc_q <= rd_acc;
            if (rd_acc) rd_addr_q <= addr_i[0];
        end
    end

    assign wr_stb  = wr_acc & ~wr_acc_q;
    assign tx_push = wr_stb & (addr_i[0] == REG_DATA);
    assign stat_wr = wr_stb & (addr_i[0] == REG_STATUS);
    assign rx_pop  = rd_acc_q & ~rd_acc & (rd_addr_q == REG_DATA);

    nanoz80_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (tx_push),
        .push_data (data_i),
        .pop       (tx_pop),
        .full      (tx_full),
        .empty     (tx_empty),
        .head      (tx_head)
    );

    nanoz80_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .full      (rx_full),
        .empty     (rx_empty),
        .head      (rx_head)
    );

    always_comb begin
        status                   = 8'h00;
        status[STAT_RX_AVAIL]    = ~rx_empty;
        status[STAT_TX_NOT_FULL] = ~tx_full;
        status[STAT_RX_OVERRUN]  = rx_overrun;
        status[STAT_FRAMING_ERR] = framing_err;
        status[STAT_TX_BUSY]     = ~tx_empty | (tx_state != IDLE);
    end

    always_comb begin
        data_o = 8'h00;
        if (rd_acc) begin
            if (addr_i[0] == REG_STATUS) data_o = status;
            else if (!rx_empty)          data_o = rx_head;
        end
    end

    assign irq_n_o = ~(~rx_empty & rx_irq_en);

    // Error sets are written last so they win over a same-cycle clear.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_irq_en   <= 1'b0;
            rx_overrun  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            if (stat_wr) begin
                rx_irq_en <= data_i[0];
                if (data_i[STAT_RX_OVERRUN])  rx_overrun  <= 1'b0;
                if (data_i[STAT_FRAMING_ERR]) framing_err <= 1'b0;
            end
            if (rx_push && rx_full && !rx_pop) rx_overrun <= 1'b1;
            if (rx_frame_err) framing_err <= 1'b1;
        end
    end

    assign tx_pop = ~tx_empty & ((tx_state == IDLE) ||
                                 (tx_state == STOP && tx_cnt == BIT_LAST));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_o     <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    tx_o   <= 1'b1;
                    tx_cnt <= '0;
                    if (!tx_empty) begin
                        tx_shift <= tx_head;
                        tx_o     <= 1'b0;
                        tx_state <= START;
                    end
                end
                START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_o     <= tx_shift[0];
                        tx_state <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_o     <= 1'b1;
                            tx_state <= STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_o     <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        // Back-to-back frames: go straight into the next start bit.
                        if (!tx_empty) begin
                            tx_shift <= tx_head;
                            tx_o     <= 1'b0;
                            tx_state <= START;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign rx_stop_sample = (rx_state == STOP) && !rx_wait_high && (rx_cnt == BIT_LAST);
    assign rx_push        = rx_stop_sample & rx_sync;
    assign rx_frame_err   = rx_stop_sample & ~rx_sync;

    // Receiver samples at bit centres: half a bit after the falling edge, then
    // one full bit apart.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_state     <= IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_wait_high <= 1'b0;
        end else begin
            case (rx_state)
                IDLE: begin
                    rx_cnt       <= '0;
                    rx_wait_high <= 1'b0;
                    if (!rx_sync) rx_state <= START;
                end
                START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_wait_high) begin
                        if (rx_sync) begin
                            rx_wait_high <= 1'b0;
                            rx_state     <= IDLE;
                        end
                    end else if (rx_cnt == BIT_LAST) begin
                        rx_cnt <= '0;
                        if (rx_sync) rx_state <= IDLE;
                        else         rx_wait_high <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nanoz80_uart.sv
// Directed self-checking bench for nanoz80_uart: register-level vector table plus
// hand-written serial frame sequences.
module tb_nanoz80_uart;

    import nanoz80_uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       rx;
    logic       tx;
    logic       irq_n;

    int compared   = 0;
    int mismatched = 0;

    typedef enum logic [1:0] {OP_IDLE, OP_WRITE, OP_READ} op_t;

    typedef struct {
        op_t        op;
        logic [7:0] addr;
        logic [7:0] data;
        int         hold;
        logic [7:0] exp_rd;
        logic       exp_irq_n;
        string      name;
    } vec_t;

    vec_t vecs[12];

    nanoz80_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .cs_i    (cs),
        .wr_n_i  (wr_n),
        .rd_n_i  (rd_n),
        .addr_i  (addr),
        .data_i  (wdata),
        .data_o  (rdata),
        .rx_i    (rx),
        .tx_o    (tx),
        .irq_n_o (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [7:0] d, input int hold);
        cs = 1'b1; wr_n = 1'b0; addr = a; wdata = d;
        repeat (hold) @(negedge clk);
        cs = 1'b0; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic busRead(input logic [7:0] a, input int hold,
                           output logic [7:0] first, output logic stable);
        logic [7:0] s;
        cs = 1'b1; rd_n = 1'b0; addr = a;
        stable = 1'b1;
        first  = 8'h00;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            s = rdata;
            if (i == 0) first = s;
            else if (s !== first) stable = 1'b0;
        end
        cs = 1'b0; rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] got;
        logic       stable;
        case (v.op)
            OP_IDLE:  repeat (v.hold) @(negedge clk);
            OP_WRITE: busWrite(v.addr, v.data, v.hold);
            default: begin
                busRead(v.addr, v.hold, got, stable);
                checkOutput(v.name, got, v.exp_rd);
                checkOutput({v.name, "_stable"}, {7'd0, stable}, 8'h01);
            end
        endcase
        checkOutput({v.name, "_irq_n"}, {7'd0, irq_n}, {7'd0, v.exp_irq_n});
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) applyStimulus(vecs[i]);
    endtask

    // Waits for a start bit, then samples every bit near its centre.
    task automatic checkTxFrame(input logic [7:0] b, input int bound, input string name);
        int         n;
        logic [7:0] got;
        n = 0;
        while (tx === 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_start_seen"}, {7'd0, tx}, 8'h00);
        if (tx !== 1'b0) return;
        repeat (CPB / 2) @(negedge clk);
        checkOutput({name, "_start"}, {7'd0, tx}, 8'h00);
        got = 8'h00;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            got[i] = tx;
        end
        checkOutput({name, "_data"}, got, b);
        repeat (CPB) @(negedge clk);
        checkOutput({name, "_stop"}, {7'd0, tx}, 8'h01);
    endtask

    task automatic sendRx(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic checkTxQuiet(input int clocks, input string name);
        logic saw_low;
        saw_low = 1'b0;
        repeat (clocks) begin
            @(negedge clk);
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        checkOutput(name, {7'd0, saw_low}, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        logic       s;

        vecs[0]  = '{OP_IDLE,  8'h00, 8'h00, 100, 8'h00, 1'b1, "idle100"};
        vecs[1]  = '{OP_READ,  8'h01, 8'h00, 2,   8'h02, 1'b1, "rst_status"};
        vecs[2]  = '{OP_READ,  8'h00, 8'h00, 2,   8'h00, 1'b1, "rst_data_empty"};
        vecs[3]  = '{OP_WRITE, 8'h01, 8'h01, 2,   8'h00, 1'b1, "irq_en_empty"};
        vecs[4]  = '{OP_READ,  8'h01, 8'h00, 2,   8'h02, 1'b1, "status_irq_en"};
        vecs[5]  = '{OP_WRITE, 8'h01, 8'h00, 2,   8'h00, 1'b1, "irq_dis"};
        vecs[6]  = '{OP_IDLE,  8'h00, 8'h00, 2,   8'h00, 1'b1, "rx_no_irq"};
        vecs[7]  = '{OP_WRITE, 8'h01, 8'h01, 4,   8'h00, 1'b0, "irq_en_set"};
        vecs[8]  = '{OP_READ,  8'h01, 8'h00, 2,   8'h03, 1'b0, "status_rx_avail"};
        vecs[9]  = '{OP_READ,  8'h00, 8'h00, 3,   8'hA5, 1'b1, "rx_data_a5"};
        vecs[10] = '{OP_READ,  8'h01, 8'h00, 2,   8'h02, 1'b1, "status_rx_empty"};
        vecs[11] = '{OP_READ,  8'h00, 8'h00, 2,   8'h00, 1'b1, "data_after_pop"};

        rst_n = 1'b0; cs = 1'b0; wr_n = 1'b1; rd_n = 1'b1;
        addr = 8'h00; wdata = 8'h00; rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] reset and register defaults");
        runVectors(0, 5);
        checkOutput("idle_tx", {7'd0, tx}, 8'h01);

        $display("[TB] single TX frame with a 4-clock write strobe");
        fork
            checkTxFrame(8'h55, 20, "tx55");
            begin
                @(negedge clk);
                cs = 1'b1; wr_n = 1'b0; addr = 8'h00; wdata = 8'h55;
                @(negedge clk);
                checkOutput("tx_lat_pre", {7'd0, tx}, 8'h01);
                @(negedge clk);
                checkOutput("tx_lat_start", {7'd0, tx}, 8'h00);
                repeat (2) @(negedge clk);
                cs = 1'b0; wr_n = 1'b1;
                repeat (3 * CPB) @(negedge clk);
                busRead(8'h01, 2, v, s);
                checkOutput("tx_busy_mid", v, 8'h12);
            end
        join
        repeat (CPB) @(negedge clk);
        busRead(8'h01, 2, v, s);
        checkOutput("tx_idle_after", v, 8'h02);

        $display("[TB] 17 back-to-back TX bytes");
        fork
            for (int i = 0; i < 17; i++) busWrite(8'h00, 8'(i), 2);
            for (int i = 0; i < 17; i++)
                checkTxFrame(8'(i), (i == 0) ? 20 : CPB, $sformatf("tx_burst%0d", i));
        join
        repeat (CPB) @(negedge clk);

        $display("[TB] TX FIFO overflow drops the extra byte");
        fork
            begin
                for (int i = 0; i < DEPTH + 2; i++) busWrite(8'h00, 8'h20 + 8'(i), 2);
                busRead(8'h01, 2, v, s);
                checkOutput("tx_full_status", v, 8'h10);
            end
            for (int i = 0; i < DEPTH + 1; i++)
                checkTxFrame(8'h20 + 8'(i), (i == 0) ? 20 : CPB, $sformatf("tx_fill%0d", i));
        join
        checkTxQuiet(20 * CPB, "tx_no_dropped_frame");
        busRead(8'h01, 2, v, s);
        checkOutput("tx_drained_status", v, 8'h02);

        $display("[TB] RX frame 0xA5 and interrupt");
        sendRx(8'hA5, 1'b1);
        repeat (CPB) @(negedge clk);
        runVectors(6, 11);

        $display("[TB] RX overrun with 17 frames");
        for (int i = 0; i < DEPTH + 1; i++) sendRx(8'h40 + 8'(i), 1'b1);
        repeat (CPB) @(negedge clk);
        busRead(8'h01, 2, v, s);
        checkOutput("rx_overrun_status", v, 8'h07);
        checkOutput("rx_overrun_irq_n", {7'd0, irq_n}, 8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            busRead(8'h00, 2, v, s);
            checkOutput($sformatf("rx_fifo%0d", i), v, 8'h40 + 8'(i));
        end
        busRead(8'h01, 2, v, s);
        checkOutput("rx_drained_status", v, 8'h06);
        busWrite(8'h01, 8'h04, 2);
        busRead(8'h01, 2, v, s);
        checkOutput("rx_overrun_cleared", v, 8'h02);

        $display("[TB] RX framing error and start-bit glitch");
        sendRx(8'h3C, 1'b0);
        repeat (CPB) @(negedge clk);
        busRead(8'h01, 2, v, s);
        checkOutput("framing_status", v, 8'h0A);
        busRead(8'h00, 2, v, s);
        checkOutput("framing_no_push", v, 8'h00);
        busWrite(8'h01, 8'h08, 2);
        busRead(8'h01, 2, v, s);
        checkOutput("framing_cleared", v, 8'h02);
        rx = 1'b0;
        repeat (CPB / 2 - 4) @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        busRead(8'h01, 2, v, s);
        checkOutput("glitch_status", v, 8'h02);

        $display("[TB] reset in the middle of a TX frame");
        busWrite(8'h00, 8'h00, 2);
        busWrite(8'h00, 8'hFF, 2);
        repeat (3 * CPB) @(negedge clk);
        checkOutput("pre_reset_tx", {7'd0, tx}, 8'h00);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_tx_high", {7'd0, tx}, 8'h01);
        rst_n = 1'b1;
        @(negedge clk);
        busRead(8'h01, 2, v, s);
        checkOutput("reset_status", v, 8'h02);
        checkTxQuiet(12 * CPB, "reset_no_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
